// File: rtl/conv_scheduler.sv
// Job sequencer for the 3x3 convolution engine: loads the kernel, then walks every
// output position of the feature map two columns at a time and writes both results.
module conv_scheduler #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [2:0]        i_stride,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_kernel_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [2:0]        o_stride,
  output logic              o_kload_start,
  output logic [ADDR_W-1:0] o_kernel_addr,
  input  logic              i_kload_done,
  output logic              o_cmd_valid,
  output logic [ADDR_W-1:0] o_cmd_src_addr,
  input  logic              i_cmd_ready,
  input  logic              i_res_valid,
  input  logic [7:0]        i_res_sum1,
  input  logic [7:0]        i_res_sum2,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data
);

  localparam int CW     = $clog2(IMG_W + IMG_H) + 1;
  localparam int OUT_W1 = IMG_W - K + 1;
  localparam int OUT_H1 = IMG_H - K + 1;
  localparam int OUT_W2 = (IMG_W - K) / 2 + 1;
  localparam int OUT_H2 = (IMG_H - K) / 2 + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD_KERNEL, WAIT_KLOAD, ISSUE, WAIT_RES, WRITE0, WRITE1, DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     out_row;
  logic [CW-1:0]     out_col;
  logic [ADDR_W-1:0] row_src_addr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        sum2_reg;

  logic [CW-1:0]     out_w;
  logic [CW-1:0]     out_h;
  logic [ADDR_W-1:0] row_step;
  logic [ADDR_W-1:0] col_step;
  logic [CW-1:0]     col_next;
  logic [CW-1:0]     row_next;
  logic              col_wrap;
  logic              has_pair;

  // Geometry follows the latched stride; only 1 and 2 can ever be latched.
  assign out_w    = (o_stride == 3'd2) ? CW'(OUT_W2) : CW'(OUT_W1);
  assign out_h    = (o_stride == 3'd2) ? CW'(OUT_H2) : CW'(OUT_H1);
  assign row_step = (o_stride == 3'd2) ? ADDR_W'(2 * IMG_W) : ADDR_W'(IMG_W);
  assign col_step = (o_stride == 3'd2) ? ADDR_W'(4) : ADDR_W'(2);
  assign col_next = out_col + CW'(2);
  assign row_next = out_row + CW'(1);
  assign col_wrap = (col_next >= out_w);
  assign has_pair = ((out_col + CW'(1)) < out_w);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      out_row        <= '0;
      out_col        <= '0;
      row_src_addr   <= '0;
      wr_ptr         <= '0;
      sum2_reg       <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_stride       <= '0;
      o_kload_start  <= 1'b0;
      o_kernel_addr  <= '0;
      o_cmd_valid    <= 1'b0;
      o_cmd_src_addr <= '0;
      o_wr_en        <= 1'b0;
      o_wr_addr      <= '0;
      o_wr_data      <= '0;
    end else begin
      o_kload_start <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_stride == 3'd1 || i_stride == 3'd2) begin
              o_stride       <= i_stride;
              o_kernel_addr  <= i_kernel_base;
              row_src_addr   <= i_src_base;
              o_cmd_src_addr <= i_src_base;
              wr_ptr         <= i_dst_base;
              out_row        <= '0;
              out_col        <= '0;
              o_busy         <= 1'b1;
              o_kload_start  <= 1'b1;
              state          <= LOAD_KERNEL;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        LOAD_KERNEL: state <= WAIT_KLOAD;
        WAIT_KLOAD: begin
          if (i_kload_done) begin
            o_cmd_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_cmd_ready) begin
            o_cmd_valid <= 1'b0;
            state       <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (i_res_valid) begin
            sum2_reg  <= i_res_sum2;
            o_wr_en   <= 1'b1;
            o_wr_addr <= wr_ptr;
            o_wr_data <= i_res_sum1;
            wr_ptr    <= wr_ptr + ADDR_W'(1);
            state     <= WRITE0;
          end
        end
        WRITE0, WRITE1: begin
          if (state == WRITE0 && has_pair) begin
            o_wr_addr <= wr_ptr;
            o_wr_data <= sum2_reg;
            wr_ptr    <= wr_ptr + ADDR_W'(1);
            state     <= WRITE1;
          end else begin
            // Advance to the next pair; addresses move by running offsets.
            o_wr_en <= 1'b0;
            if (col_wrap) begin
              out_col        <= '0;
              out_row        <= row_next;
              row_src_addr   <= row_src_addr + row_step;
              o_cmd_src_addr <= row_src_addr + row_step;
            end else begin
              out_col        <= col_next;
              o_cmd_src_addr <= o_cmd_src_addr + col_step;
            end
            if (col_wrap && row_next == out_h) begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= DONE;
            end else begin
              o_cmd_valid <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Randomized scoreboard bench for conv_scheduler: an engine model answers commands,
// a monitor checks every command and write against the geometric reference.
`timescale 1ns/1ps
module tb_conv_scheduler;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int K      = 3;
  localparam int ADDR_W = 10;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b0;
  logic [2:0]        i_stride = '0;
  logic [ADDR_W-1:0] i_src_base = '0;
  logic [ADDR_W-1:0] i_kernel_base = '0;
  logic [ADDR_W-1:0] i_dst_base = '0;
  logic              i_kload_done = 1'b0;
  logic              i_cmd_ready = 1'b0;
  logic              i_res_valid = 1'b0;
  logic [7:0]        i_res_sum1 = '0;
  logic [7:0]        i_res_sum2 = '0;
  logic              o_busy, o_done, o_err, o_kload_start, o_cmd_valid, o_wr_en;
  logic [2:0]        o_stride;
  logic [ADDR_W-1:0] o_kernel_addr, o_cmd_src_addr, o_wr_addr;
  logic [7:0]        o_wr_data;

  conv_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stride(i_stride),
    .i_src_base(i_src_base), .i_kernel_base(i_kernel_base), .i_dst_base(i_dst_base),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_stride(o_stride),
    .o_kload_start(o_kload_start), .o_kernel_addr(o_kernel_addr),
    .i_kload_done(i_kload_done), .o_cmd_valid(o_cmd_valid),
    .o_cmd_src_addr(o_cmd_src_addr), .i_cmd_ready(i_cmd_ready),
    .i_res_valid(i_res_valid), .i_res_sum1(i_res_sum1), .i_res_sum2(i_res_sum2),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic [ADDR_W-1:0] exp_cmd_q[$];
  wr_t               exp_wr_q[$];
  int checks = 0;
  int errors = 0;
  int job_dst = 0, job_outw = 1, job_cpr = 1, exp_total = 0;
  logic [ADDR_W-1:0] exp_kaddr = '0;
  logic [2:0]        exp_stride = '0;
  int wr_cnt = 0, cmd_cnt = 0, done_cnt = 0;
  bit rnd_mode = 1'b0, bp_mode = 1'b0, spur_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Engine model: kernel load, ready/backpressure, results, spurious strobes.
  int hs_pend = 0, res_wait = -1, kl_cnt = -1, res_idx = 0, hs_seen = 0, hold_cnt = 0;
  always @(negedge i_clk) begin
    i_res_valid = 1'b0;
    if (i_rst) begin
      hs_pend = 0; res_wait = -1; kl_cnt = -1;
      i_kload_done = 1'b0; i_cmd_ready = 1'b0;
    end else begin
      if (o_kload_start) begin
        res_idx = 0; hs_seen = 0; hold_cnt = 0;
        kl_cnt = rnd_mode ? int'($urandom_range(1, 4)) : 1;
      end else if (kl_cnt > 0) begin
        kl_cnt--;
        if (kl_cnt == 0) i_kload_done = 1'b1;
      end
      if (o_cmd_valid) i_kload_done = 1'b0;
      if (hs_pend != 0) begin
        res_wait = rnd_mode ? int'($urandom_range(0, 2)) : 0;
        hs_pend = 0;
      end
      if (res_wait == 0) begin
        int row, col;
        wr_t w;
        i_res_valid = 1'b1;
        i_res_sum1 = 8'($urandom);
        i_res_sum2 = 8'($urandom);
        row = res_idx / job_cpr;
        col = (res_idx % job_cpr) * 2;
        w.addr = ADDR_W'(job_dst + row * job_outw + col);
        w.data = i_res_sum1;
        exp_wr_q.push_back(w);
        if (col + 1 < job_outw) begin
          w.addr = w.addr + ADDR_W'(1);
          w.data = i_res_sum2;
          exp_wr_q.push_back(w);
        end
        res_idx++;
        res_wait = -1;
      end else if (res_wait > 0) begin
        res_wait--;
      end
      if (bp_mode) begin
        if (hs_seen == 2 && hold_cnt < 5 && o_cmd_valid) begin
          i_cmd_ready = 1'b0;
          hold_cnt++;
        end else begin
          i_cmd_ready = 1'b1;
        end
      end else if (rnd_mode) begin
        i_cmd_ready = ($urandom % 3) != 0;
      end else begin
        i_cmd_ready = 1'b1;
      end
      if (spur_mode && o_cmd_valid && !i_cmd_ready && ($urandom % 2) == 0) begin
        i_res_valid = 1'b1;
        i_res_sum1 = 8'($urandom);
        i_res_sum2 = 8'($urandom);
      end
      if (o_cmd_valid && i_cmd_ready) begin
        hs_pend = 1;
        hs_seen++;
      end
    end
  end

  // Monitor: samples mid-cycle, after the engine has set up the next edge's inputs.
  bit                prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  always @(negedge i_clk) begin
    #2;
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (o_kload_start) begin
        wr_cnt = 0; cmd_cnt = 0;
        check("kernel_addr", 32'(o_kernel_addr), 32'(exp_kaddr));
        check("stride_out", 32'(o_stride), 32'(exp_stride));
      end
      if (prev_stall) begin
        check("stall_valid", 32'(o_cmd_valid), 32'd1);
        check("stall_addr", 32'(o_cmd_src_addr), 32'(prev_addr));
      end
      if (o_cmd_valid && i_cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_extra: got addr %0d expected no command", o_cmd_src_addr);
        end else begin
          logic [ADDR_W-1:0] e;
          e = exp_cmd_q.pop_front();
          check("cmd_addr", 32'(o_cmd_src_addr), 32'(e));
        end
        cmd_cnt++;
      end
      prev_stall = o_cmd_valid && !i_cmd_ready;
      prev_addr  = o_cmd_src_addr;
      if (o_wr_en) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_extra: got addr %0d data %0d expected no write", o_wr_addr, o_wr_data);
        end else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          check("wr_addr", 32'(o_wr_addr), 32'(w.addr));
          check("wr_data", 32'(o_wr_data), 32'(w.data));
        end
        wr_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        check("done_writes", 32'(wr_cnt), 32'(exp_total));
        check("done_cmd_left", 32'(exp_cmd_q.size()), 32'd0);
        check("done_wr_left", 32'(exp_wr_q.size()), 32'd0);
      end
    end
  end

  task automatic start_job(input int s, input logic [ADDR_W-1:0] src,
                           input logic [ADDR_W-1:0] kb, input logic [ADDR_W-1:0] dst);
    int ow, oh;
    ow = (IMG_W - K) / s + 1;
    oh = (IMG_H - K) / s + 1;
    exp_cmd_q.delete();
    exp_wr_q.delete();
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c += 2)
        exp_cmd_q.push_back(ADDR_W'(int'(src) + r * s * IMG_W + c * s));
    job_dst = int'(dst); job_outw = ow; job_cpr = (ow + 1) / 2; exp_total = ow * oh;
    exp_kaddr = kb; exp_stride = 3'(s);
    $display("job stride=%0d src=%0d kernel=%0d dst=%0d cmds=%0d writes=%0d",
             s, src, kb, dst, exp_cmd_q.size(), exp_total);
    @(negedge i_clk);
    i_start = 1'b1; i_stride = 3'(s);
    i_src_base = src; i_kernel_base = kb; i_dst_base = dst;
    @(negedge i_clk);
    i_start = 1'b0;
    i_src_base = ADDR_W'($urandom); i_kernel_base = ADDR_W'($urandom);
    i_dst_base = ADDR_W'($urandom); i_stride = 3'($urandom);
    check("start_busy_kload", {30'd0, o_busy, o_kload_start}, 32'd3);
  endtask

  task automatic wait_done();
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(negedge i_clk);
      n++;
    end
    check("job_done", 32'(done_cnt - d0), 32'd1);
    repeat (4) @(negedge i_clk);
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("idle_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {23'd0, o_busy, o_done, o_err, o_kload_start, o_cmd_valid, o_wr_en, o_stride}, 32'd0);
    check({tag, "_addr"}, {2'd0, o_kernel_addr, o_cmd_src_addr, o_wr_addr}, 32'd0);
    check({tag, "_data"}, 32'(o_wr_data), 32'd0);
  endtask

  initial begin
    int n, d0, bad;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_rst = 1'b0;

    // Plain stride-1 job, ideal engine.
    start_job(1, 10'd0, 10'd5, 10'd0);
    wait_done();

    // Stride-2 job with random readiness and result latency.
    rnd_mode = 1'b1;
    start_job(2, 10'd100, 10'd33, 10'd200);
    wait_done();
    rnd_mode = 1'b0;

    // Illegal stride is rejected and latches nothing.
    @(negedge i_clk);
    i_start = 1'b1; i_stride = 3'd3; i_kernel_base = 10'd777;
    @(negedge i_clk);
    i_start = 1'b0;
    check("err_pulse", 32'(o_err), 32'd1);
    check("err_busy", 32'(o_busy), 32'd0);
    check("err_stride_kept", 32'(o_stride), 32'd2);
    bad = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_err || o_busy || o_kload_start || o_cmd_valid || o_wr_en) bad++;
    end
    check("err_quiet", 32'(bad), 32'd0);

    // Backpressure on the third command.
    bp_mode = 1'b1;
    start_job(1, 10'd0, 10'd9, 10'd0);
    wait_done();
    bp_mode = 1'b0;

    // Reset in the middle of a job, then restart it.
    rnd_mode = 1'b1;
    start_job(2, 10'd60, 10'd1, 10'd500);
    n = 0;
    while (wr_cnt < 10 && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    check("midjob_reached", 32'(wr_cnt >= 10), 32'd1);
    d0 = done_cnt;
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    check_all_zero("midjob_reset");
    repeat (3) @(negedge i_clk);
    check("midjob_no_done", 32'(done_cnt - d0), 32'd0);
    i_rst = 1'b0;
    start_job(2, 10'd60, 10'd1, 10'd500);
    wait_done();

    // Start during WAIT_RES and spurious results during ISSUE are ignored.
    spur_mode = 1'b1;
    start_job(1, 10'd900, 10'd3, 10'd700);
    n = 0;
    while (!(cmd_cnt >= 5 && o_busy && !o_cmd_valid && !o_wr_en && !o_kload_start) && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    check("poke_window", 32'(n < 5000), 32'd1);
    i_start = 1'b1; i_stride = 3'd2; i_src_base = 10'd5; i_dst_base = 10'd5;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_done();
    spur_mode = 1'b0;

    // A couple of fully random jobs, including address wrap-around.
    repeat (2) begin
      start_job(int'($urandom_range(1, 2)), ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom));
      wait_done();
    end
    rnd_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
